shift_pipe: RTL and testbench



---
 rtl/shift_pipe.sv | 97 +++++++++
 tb/tb_shift_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// shift_pipe: DEPTH-stage valid/ready register pipeline with bubble collapsing and synchronous flush.
// Define SHIFT_PIPE_OCC_EN to add the registered `occupancy` output (count of valid stages).
`timescale 1ns/1ps
module shift_pipe #(
    parameter int DWIDTH = 1,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data
`ifdef SHIFT_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0]  v;
    logic [DEPTH-1:0]  v_src;
    logic [DEPTH-1:0]  adv;
    logic [DWIDTH-1:0] d     [DEPTH];
    logic [DWIDTH-1:0] d_src [DEPTH];

    // A stage may advance when any stage at or after it is empty, or the sink takes a word.
    always_comb begin : adv_chain
        logic room;
        room = m_ready;
        adv  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            room   = room | ~v[i];
            adv[i] = room;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_src
        if (i == 0) begin : g_head
            assign v_src[i] = s_valid;
            assign d_src[i] = s_data;
        end else begin : g_body
            assign v_src[i] = v[i-1];
            assign d_src[i] = d[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v[i] <= v_src[i];
                    d[i] <= d_src[i];
                end
            end
        end
    end

    assign s_ready = adv[0] & ~flush;
    assign m_valid = v[DEPTH-1] & ~flush;
    assign m_data  = d[DEPTH-1];

`ifdef SHIFT_PIPE_OCC_EN
    localparam int OW = $clog2(DEPTH + 1);

    logic          in_hs;
    logic          out_hs;
    logic [OW-1:0] occ_q;

    assign in_hs  = s_valid & s_ready;
    assign out_hs = m_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (in_hs && !out_hs) begin
            occ_q <= occ_q + OW'(1);
        end else if (out_hs && !in_hs) begin
            occ_q <= occ_q - OW'(1);
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (DWIDTH=8, DEPTH=4): directed table, hand sequences, random scoreboard.
`timescale 1ns/1ps
module tb_shift_pipe;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef SHIFT_PIPE_OCC_EN
    logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

    shift_pipe #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data)
`ifdef SHIFT_PIPE_OCC_EN
        ,
        .occupancy(occupancy)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: words in flight in acceptance order, each with the number of edges since
    // acceptance. The oldest word is presented once it has spent DEPTH edges in the pipe; input is
    // refused only when all DEPTH slots are in use and the sink is not taking a word.
    typedef struct {
        logic [DW-1:0] data;
        int            age;
    } word_t;

    word_t q[$];
    logic  last_f;
    logic  in_hs_e;
    logic  out_hs_e;

    function automatic logic exp_sr(input logic f, input logic mr);
        return !f && ((q.size() < DEPTH) || mr);
    endfunction

    function automatic logic exp_mv(input logic f);
        return !f && (q.size() > 0) && (q[0].age >= DEPTH);
    endfunction

    task automatic drive_sample(input logic f, input logic sv, input logic [DW-1:0] sd, input logic mr);
        logic e_sr;
        logic e_mv;
        flush   = f;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(negedge clk);
        e_sr = exp_sr(f, mr);
        e_mv = exp_mv(f);
        chk("s_ready", 32'(s_ready), 32'(e_sr));
        chk("m_valid", 32'(m_valid), 32'(e_mv));
        if (e_mv) chk("m_data", 32'(m_data), 32'(q[0].data));
`ifdef SHIFT_PIPE_OCC_EN
        chk("occupancy", 32'(occupancy), 32'(q.size()));
`endif
        last_f   = f;
        in_hs_e  = sv & e_sr;
        out_hs_e = e_mv & mr;
    endtask

    task automatic advance();
        word_t w;
        @(posedge clk);
        #1;
        if (last_f) begin
            q.delete();
        end else begin
            if (out_hs_e) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (in_hs_e) begin
                w.data = s_data;
                w.age  = 1;
                q.push_back(w);
            end
        end
    endtask

    task automatic step(input logic f, input logic sv, input logic [DW-1:0] sd, input logic mr);
        drive_sample(f, sv, sd, mr);
        advance();
    endtask

    typedef struct packed {
        logic          f;
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic          e_sr;
        logic          e_mv;
        logic [DW-1:0] e_md;
        logic [2:0]    e_occ;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic sv, input logic [DW-1:0] sd, input logic mr,
                                 input logic e_sr, input logic e_mv, input logic [DW-1:0] e_md,
                                 input logic [2:0] e_occ);
        vec_t r;
        r.f = 1'b0; r.sv = sv; r.sd = sd; r.mr = mr;
        r.e_sr = e_sr; r.e_mv = e_mv; r.e_md = e_md; r.e_occ = e_occ;
        return r;
    endfunction

    vec_t t;

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        last_f  = 1'b0;
        in_hs_e = 1'b0;
        out_hs_e = 1'b0;

        // Stall fill then drain, followed by a single word with bubbles filled behind it.
        tbl.push_back(mkv(1, 8'hA0, 0, 1, 0, 8'h00, 3'd0));
        tbl.push_back(mkv(1, 8'hA1, 0, 1, 0, 8'h00, 3'd1));
        tbl.push_back(mkv(1, 8'hA2, 0, 1, 0, 8'h00, 3'd2));
        tbl.push_back(mkv(1, 8'hA3, 0, 1, 0, 8'h00, 3'd3));
        tbl.push_back(mkv(1, 8'hEE, 0, 0, 1, 8'hA0, 3'd4));
        tbl.push_back(mkv(0, 8'h00, 1, 1, 1, 8'hA0, 3'd4));
        tbl.push_back(mkv(0, 8'h00, 1, 1, 1, 8'hA1, 3'd3));
        tbl.push_back(mkv(0, 8'h00, 1, 1, 1, 8'hA2, 3'd2));
        tbl.push_back(mkv(0, 8'h00, 1, 1, 1, 8'hA3, 3'd1));
        tbl.push_back(mkv(0, 8'h00, 1, 1, 0, 8'h00, 3'd0));
        tbl.push_back(mkv(1, 8'h55, 0, 1, 0, 8'h00, 3'd0));
        tbl.push_back(mkv(0, 8'h00, 0, 1, 0, 8'h00, 3'd1));
        tbl.push_back(mkv(0, 8'h00, 0, 1, 0, 8'h00, 3'd1));
        tbl.push_back(mkv(0, 8'h00, 0, 1, 0, 8'h00, 3'd1));
        tbl.push_back(mkv(1, 8'h66, 0, 1, 1, 8'h55, 3'd1));
        tbl.push_back(mkv(1, 8'h77, 0, 1, 1, 8'h55, 3'd2));
        tbl.push_back(mkv(0, 8'h00, 0, 1, 1, 8'h55, 3'd3));
        tbl.push_back(mkv(0, 8'h00, 1, 1, 1, 8'h55, 3'd3));
        tbl.push_back(mkv(0, 8'h00, 1, 1, 1, 8'h66, 3'd2));
        tbl.push_back(mkv(0, 8'h00, 1, 1, 1, 8'h77, 3'd1));
        tbl.push_back(mkv(0, 8'h00, 1, 1, 0, 8'h00, 3'd0));

        #2;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
`ifdef SHIFT_PIPE_OCC_EN
        chk("rst_occupancy", 32'(occupancy), 32'd0);
`endif
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream with m_ready high: fixed latency of DEPTH, no gaps.
        for (int c = 0; c < 20; c++) begin
            drive_sample(0, (c < 16), 8'(c + 1), 1);
            chk("lat_m_valid", 32'(m_valid), 32'(c >= 4));
            if (c >= 4) chk("lat_m_data", 32'(m_data), 32'(c - 3));
            advance();
        end

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            drive_sample(t.f, t.sv, t.sd, t.mr);
            chk($sformatf("tbl%0d_s_ready", i), 32'(s_ready), 32'(t.e_sr));
            chk($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(t.e_mv));
            if (t.e_mv) chk($sformatf("tbl%0d_m_data", i), 32'(m_data), 32'(t.e_md));
`ifdef SHIFT_PIPE_OCC_EN
            chk($sformatf("tbl%0d_occupancy", i), 32'(occupancy), 32'(t.e_occ));
`endif
            advance();
        end

        // Flush with three words in flight, then a fresh word after the flush.
        step(0, 1, 8'h11, 0);
        step(0, 1, 8'h22, 0);
        step(0, 1, 8'h33, 0);
        drive_sample(1, 1, 8'h44, 1);
        chk("flush_s_ready", 32'(s_ready), 32'd0);
        chk("flush_m_valid", 32'(m_valid), 32'd0);
        advance();
        drive_sample(0, 1, 8'h99, 1);
        chk("post_flush_m_valid", 32'(m_valid), 32'd0);
        chk("post_flush_s_ready", 32'(s_ready), 32'd1);
`ifdef SHIFT_PIPE_OCC_EN
        chk("post_flush_occupancy", 32'(occupancy), 32'd0);
`endif
        advance();
        for (int k = 1; k <= 4; k++) begin
            drive_sample(0, 0, 8'h00, 1);
            chk("flush_lat_m_valid", 32'(m_valid), 32'(k == 4));
            if (k == 4) chk("flush_lat_m_data", 32'(m_data), 32'h99);
            advance();
        end

        // Asynchronous reset between edges with a full pipeline.
        step(0, 1, 8'hC1, 0);
        step(0, 1, 8'hC2, 0);
        step(0, 1, 8'hC3, 0);
        step(0, 1, 8'hC4, 0);
        s_valid = 1'b0;
        m_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_m_valid", 32'(m_valid), 32'd0);
        chk("async_rst_m_data", 32'(m_data), 32'd0);
        chk("async_rst_s_ready", 32'(s_ready), 32'd1);
`ifdef SHIFT_PIPE_OCC_EN
        chk("async_rst_occupancy", 32'(occupancy), 32'd0);
`endif
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 1, 8'h3C, 1);
        for (int k = 1; k <= 4; k++) begin
            drive_sample(0, 0, 8'h00, 1);
            chk("rst_lat_m_valid", 32'(m_valid), 32'(k == 4));
            if (k == 4) chk("rst_lat_m_data", 32'(m_data), 32'h3C);
            advance();
        end

        // Random traffic against the reference model, with an occasional flush.
        for (int c = 0; c < 10000; c++) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
